// File: rtl/data_mem_controller_pkg.sv
// Shared definitions for the MEM-stage data memory controller:
// FSM state encoding, byte-enable constants and the alignment rule.
// Optional feature macro used by the controller: MIPS32_LLSC_EN.
package data_mem_controller_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [3:0] BE_WORD = 4'b1111;
   localparam logic [3:0] BE_HI   = 4'b1100;
   localparam logic [3:0] BE_LO   = 4'b0011;
   localparam logic [3:0] BE_NONE = 4'b0000;

   // Byte accesses are always aligned; half needs an even address; word needs addr[1:0]=0.
   function automatic logic is_aligned(input logic byte_sel, input logic half_sel,
                                       input logic [1:0] addr_low);
      if (byte_sel)
         return 1'b1;
      else if (half_sel)
         return ~addr_low[0];
      else
         return addr_low == 2'b00;
   endfunction

endpackage

// File: rtl/data_mem_controller_lane.sv
// mem_lane_align: big-endian lane selection for loads (right-justify and
// sign/zero extend) and for stores (lane replication and byte enables).
// Purely combinational.
module mem_lane_align
   import data_mem_controller_pkg::*;
(
   input  logic [1:0]  addr_low,
   input  logic        byte_sel,
   input  logic        half_sel,
   input  logic        sign_ext,
   input  logic [31:0] load_word,
   input  logic [31:0] store_word,
   output logic [31:0] load_data,
   output logic [31:0] store_data,
   output logic [3:0]  byte_en
);

   logic [7:0]  lane_byte;
   logic [15:0] lane_half;

   // Load path: pick the addressed lane (lane 0 is bits 31:24) and extend it.
   always_comb begin
      lane_byte = 8'h00;
      lane_half = addr_low[1] ? load_word[15:0] : load_word[31:16];
      case (addr_low)
         2'd0:    lane_byte = load_word[31:24];
         2'd1:    lane_byte = load_word[23:16];
         2'd2:    lane_byte = load_word[15:8];
         default: lane_byte = load_word[7:0];
      endcase
      if (byte_sel)
         load_data = {{24{sign_ext & lane_byte[7]}}, lane_byte};
      else if (half_sel)
         load_data = {{16{sign_ext & lane_half[15]}}, lane_half};
      else
         load_data = load_word;
   end

   // Store path: replicate the datum on every lane and enable only the addressed bytes.
   always_comb begin
      store_data = store_word;
      byte_en    = BE_WORD;
      if (byte_sel) begin
         store_data = {4{store_word[7:0]}};
         byte_en    = 4'b1000 >> addr_low;
      end else if (half_sel) begin
         store_data = {2{store_word[15:0]}};
         byte_en    = addr_low[1] ? BE_LO : BE_HI;
      end
   end

endmodule

// File: rtl/data_mem_controller.sv
// MEM-stage data memory controller: checks alignment, stalls the pipeline
// while a load/store is outstanding, and returns aligned load data or SC status.
// Handshake: an access is presented on DataMem_Read/DataMem_Write (with
// address and data held stable) from the first WAIT cycle until the cycle in
// which DataMem_Ack is high; Ack in any other state is ignored.
// Optional LL/SC link tracking is enabled by defining MIPS32_LLSC_EN.
module data_mem_controller
   import data_mem_controller_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        MEM_MemRead,
   input  logic        MEM_MemWrite,
   input  logic        MEM_Byte,
   input  logic        MEM_Half,
   input  logic        MEM_SignExtend,
   input  logic        MEM_LLSC,
   input  logic [31:0] MEM_Address,
   input  logic [31:0] MEM_WriteData,
   input  logic        M_Stall,
   input  logic        Eret,
   output logic [31:0] ReadData,
   output logic        M_Stall_Controller,
   output logic        EXC_AdEL,
   output logic        EXC_AdES,
   input  logic [31:0] DataMem_In,
   input  logic        DataMem_Ack,
   output logic        DataMem_Read,
   output logic [3:0]  DataMem_Write,
   output logic [29:0] DataMem_Address,
   output logic [31:0] DataMem_Out,
   output state_t      fsm_state
);

   state_t      state, next_state;
   logic        request, aligned, sc_fail, start, finish, stall;
   logic        req_read, req_sc, req_byte, req_half, req_sign;
   logic [1:0]  req_low;
   logic        read_q;
   logic [3:0]  write_q;
   logic [29:0] addr_q;
   logic [31:0] out_q, data_q;
   logic [1:0]  sel_low;
   logic        sel_byte, sel_half, sel_sign;
   logic [31:0] load_data, store_data;
   logic [3:0]  byte_en;

   assign request = MEM_MemRead | MEM_MemWrite;
   assign aligned = is_aligned(MEM_Byte, MEM_Half, MEM_Address[1:0]);
   assign start   = (state == IDLE) & request & aligned & ~sc_fail;
   assign finish  = (state == WAIT) & DataMem_Ack;

`ifdef MIPS32_LLSC_EN
   logic        link_bit;
   logic [29:0] link_addr;
   logic        req_ll;

   // An SC without a matching live link fails locally and never reaches memory.
   assign sc_fail = MEM_MemWrite & MEM_LLSC &
                    ~(link_bit & (link_addr == MEM_Address[31:2]));

   // Link tracking: LL sets the link at Ack, SC consumes it, Eret kills it.
   always_ff @(posedge clock) begin
      if (reset) begin
         link_bit  <= 1'b0;
         link_addr <= '0;
         req_ll    <= 1'b0;
      end else begin
         if (start)
            req_ll <= MEM_MemRead & MEM_LLSC;
         if (Eret) begin
            link_bit <= 1'b0;
         end else if (finish) begin
            if (req_ll) begin
               link_bit  <= 1'b1;
               link_addr <= addr_q;
            end else if (req_sc) begin
               link_bit <= 1'b0;
            end
         end
      end
   end
`else
   // Without link tracking every SC is an ordinary store that reports success.
   logic unused_eret;
   assign sc_fail     = 1'b0;
   assign unused_eret = Eret;
`endif

   // The aligner sees the live request while idle (store lanes) and the
   // captured request afterwards (load lanes at Ack time).
   assign sel_low  = (state == IDLE) ? MEM_Address[1:0] : req_low;
   assign sel_byte = (state == IDLE) ? MEM_Byte         : req_byte;
   assign sel_half = (state == IDLE) ? MEM_Half         : req_half;
   assign sel_sign = (state == IDLE) ? MEM_SignExtend   : req_sign;

   mem_lane_align u_lane (
      .addr_low   (sel_low),
      .byte_sel   (sel_byte),
      .half_sel   (sel_half),
      .sign_ext   (sel_sign),
      .load_word  (DataMem_In),
      .store_word (MEM_WriteData),
      .load_data  (load_data),
      .store_data (store_data),
      .byte_en    (byte_en)
   );

   // FSM state register.
   always_ff @(posedge clock) begin
      if (reset)
         state <= IDLE;
      else
         state <= next_state;
   end

   // Next state and stall; the stall is raised in the request cycle itself.
   always_comb begin
      next_state = state;
      stall      = 1'b0;
      case (state)
         IDLE: begin
            if (request && aligned && !sc_fail) begin
               stall      = 1'b1;
               next_state = WAIT;
            end
         end
         WAIT: begin
            stall = 1'b1;
            if (DataMem_Ack)
               next_state = DONE;
         end
         DONE: begin
            if (!M_Stall)
               next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Memory-side request registers and the load/SC result latch.
   always_ff @(posedge clock) begin
      if (reset) begin
         read_q   <= 1'b0;
         write_q  <= BE_NONE;
         addr_q   <= '0;
         out_q    <= '0;
         data_q   <= '0;
         req_read <= 1'b0;
         req_sc   <= 1'b0;
         req_byte <= 1'b0;
         req_half <= 1'b0;
         req_sign <= 1'b0;
         req_low  <= 2'b00;
      end else if (start) begin
         read_q   <= MEM_MemRead;
         write_q  <= (MEM_MemWrite && !MEM_MemRead) ? byte_en : BE_NONE;
         addr_q   <= MEM_Address[31:2];
         out_q    <= store_data;
         req_read <= MEM_MemRead;
         req_sc   <= MEM_MemWrite & MEM_LLSC;
         req_byte <= MEM_Byte;
         req_half <= MEM_Half;
         req_sign <= MEM_SignExtend;
         req_low  <= MEM_Address[1:0];
      end else if (finish) begin
         read_q  <= 1'b0;
         write_q <= BE_NONE;
         data_q  <= req_read ? load_data : {31'b0, req_sc};
      end
   end

   assign DataMem_Read       = read_q;
   assign DataMem_Write      = write_q;
   assign DataMem_Address    = addr_q;
   assign DataMem_Out        = out_q;
   assign M_Stall_Controller = stall & ~reset;
   assign EXC_AdEL           = ~reset & (state == IDLE) & MEM_MemRead & ~aligned;
   assign EXC_AdES           = ~reset & (state == IDLE) & MEM_MemWrite & ~aligned;
   assign ReadData           = (!reset && state == DONE) ? data_q : 32'h0;
   assign fsm_state          = state;

endmodule

// File: doc/data_mem_controller.md
DATA_MEM_CONTROLLER -- requirements
Module: data_mem_controller

Interface
REQ-001 Parameters: none.
REQ-002 One clock; reset is synchronous and active-high; ports are named clock and reset.
REQ-003 clock  in  1  rising-edge clock for all state.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 MEM_MemRead / MEM_MemWrite  in  1 each  MEM-stage load / store request.
REQ-006 MEM_Byte, MEM_Half  in  1 each  access size; neither asserted means word.
REQ-007 MEM_SignExtend  in  1  sign-extend byte/half loads.
REQ-008 MEM_LLSC  in  1  marks LL (with read) or SC (with write).
REQ-009 MEM_Address  in  32  byte address; MEM_WriteData  in  32  store data.
REQ-010 M_Stall  in  1  global MEM-stage stall from hazard unit.
REQ-011 Eret  in  1  clears LL link bit.
REQ-012 ReadData  out  32  aligned, extended load result, or SC status.
REQ-013 M_Stall_Controller  out  1  MEM stage must hold.
REQ-014 EXC_AdEL / EXC_AdES  out  1 each  load / store address error.
REQ-015 DataMem_In  in  32 and DataMem_Ack  in  1  memory read data and completion.
REQ-016 DataMem_Read  out  1; DataMem_Write  out  4  byte enables (bit3 = bits 31:24).
REQ-017 DataMem_Address  out  30  word address; DataMem_Out  out  32  lane-replicated write data.

Function
REQ-018 FSM states SHALL be IDLE, WAIT, DONE.
REQ-019 Alignment: word needs addr[1:0]=0, half needs addr[0]=0; violation SHALL raise EXC_AdEL (read) or EXC_AdES (write) combinationally, with no memory access and no stall.
REQ-020 IDLE with an aligned request SHALL assert M_Stall_Controller combinationally in that cycle and go to WAIT.
REQ-021 WAIT SHALL drive registered DataMem_Read or DataMem_Write plus address/data, hold M_Stall_Controller=1 and remain in WAIT until DataMem_Ack.
REQ-022 On Ack: DataMem_Read/Write SHALL drop the next cycle, load data SHALL be latched, and the FSM SHALL enter DONE.
REQ-023 DONE SHALL drive M_Stall_Controller=0 and present the latched ReadData, holding until M_Stall=0, then return to IDLE.
REQ-024 Minimum latency: request at cycle 0 with Ack at cycle 1 gives stall in cycles 0-1 and data valid in cycle 2.
REQ-025 Endianness is big; byte lane at addr[1:0]=0 is bits 31:24. Byte writes SHALL use a one-hot enable, half writes 1100 or 0011, word writes 1111.
REQ-026 Byte/half loads SHALL be right-justified and sign- or zero-extended per MEM_SignExtend.
REQ-027 DataMem_Ack outside WAIT SHALL be ignored.
REQ-028 A request held in DONE SHALL NOT start a second access.

Reset
REQ-029 Reset SHALL set state=IDLE, clear the link bit and link address, and drive every output to 0.
REQ-030 Reset during WAIT SHALL abort the access; DataMem_Read/Write SHALL be 0 from the next edge, and a late Ack SHALL be ignored.

Configuration
REQ-031 Macro MIPS32_LLSC_EN defined: LL SHALL set the link bit and record addr[31:2] at Ack.
REQ-032 With the macro, SC SHALL succeed only if the link bit is set and the address matches; success writes memory, returns ReadData=1 and clears the link bit.
REQ-033 With the macro, a failing SC SHALL NOT access memory or stall, and SHALL return ReadData=0.
REQ-034 With the macro, Eret SHALL clear the link bit.
REQ-035 Macro undefined: LL SHALL behave as LW; SC SHALL behave as SW returning ReadData=1; no link state SHALL exist.

Structure
REQ-036 The shared package SHALL hold the FSM state encoding and the byte-enable constants (BE_WORD=1111, BE_HI=1100, BE_LO=0011).
REQ-037 Lane select and extend logic SHALL be one combinational sub-module, mem_lane_align.

Verification
REQ-038 LW at 0x100, Ack 3 cycles later, DataMem_In=0xDEADBEEF -> stall for 4 cycles, then ReadData=0xDEADBEEF.
REQ-039 LB signed at 0x103 with DataMem_In=0x000000F0 -> ReadData=0xFFFFFFF0; unsigned -> 0x000000F0.
REQ-040 SH at 0x102 with data 0x1234 -> DataMem_Write=0011, DataMem_Out=0x12341234, DataMem_Address=0x40.
REQ-041 LW at 0x101 -> EXC_AdEL=1, DataMem_Read=0, M_Stall_Controller=0.
REQ-042 With macro: LL at 0x200, then SC at 0x200 -> ReadData=1 and memory written; a second SC -> ReadData=0 and no write.
REQ-043 Reset asserted in WAIT with a late Ack -> IDLE, all outputs 0, the late Ack ignored.
